// File: rtl/sr_pq_param.sv
// rtl/sr_pq_param.sv - sorted shift-register priority queue, parametrised width/depth/order
package pq_pkg;
    typedef enum logic {MIN_PQ = 1'b0, MAX_PQ = 1'b1} pq_type_t;
endpackage

module sr_pq_param #(
    parameter int               KEY_WIDTH = 32,
    parameter int               VAL_WIDTH = 32,
    parameter int               CAPACITY  = 8,
    parameter pq_pkg::pq_type_t PQ_TYPE   = pq_pkg::MIN_PQ,
    localparam int              CW        = $clog2(CAPACITY + 1),
    localparam int              W         = KEY_WIDTH + VAL_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enq,
    input  logic          deq,
    input  logic [W-1:0]  kvi,
    output logic [W-1:0]  kvo,
    output logic          kvo_v,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          err
);

    logic [CAPACITY-1:0] slot_v;
    logic [W-1:0]        slot_d [CAPACITY];
    logic [CW-1:0]       cnt;
    logic                err_r;

    logic                is_full, is_empty, do_deq, do_enq, err_nxt;
    logic [CAPACITY:0]   cmp;
    logic [CAPACITY-1:0] cmp_s, cmp_p;
    logic [CAPACITY-1:0] base_v, prev_v, nxt_v;
    logic [W-1:0]        base_d [CAPACITY];
    logic [W-1:0]        prev_d [CAPACITY];
    logic [W-1:0]        nxt_d  [CAPACITY];

    function automatic logic beats(input logic [KEY_WIDTH-1:0] a, input logic [KEY_WIDTH-1:0] b);
        if (PQ_TYPE == pq_pkg::MAX_PQ) return a > b;
        else                           return a < b;
    endfunction

    assign is_full  = (cnt == CW'(CAPACITY));
    assign is_empty = (cnt == '0);
    assign do_deq   = deq && !is_empty;
    assign do_enq   = enq && (!is_full || do_deq);
    assign err_nxt  = (enq && !deq && is_full) || (deq && is_empty);

    always_comb begin
        // cmp[i]: kvi belongs ahead of slot i (empty slots always lose)
        cmp = '0;
        for (int i = 0; i < CAPACITY; i++)
            cmp[i] = !slot_v[i] || beats(kvi[W-1 -: KEY_WIDTH], slot_d[i][W-1 -: KEY_WIDTH]);
        cmp[CAPACITY] = 1'b1;

        // base_*: contents after an optional dequeue shift-up
        for (int i = 0; i < CAPACITY; i++) begin
            cmp_s[i] = do_deq ? cmp[i+1] : cmp[i];
            if (do_deq && i < CAPACITY - 1) begin
                base_v[i] = slot_v[i+1];
                base_d[i] = slot_d[i+1];
            end else if (do_deq) begin
                base_v[i] = 1'b0;
                base_d[i] = '0;
            end else begin
                base_v[i] = slot_v[i];
                base_d[i] = slot_d[i];
            end
        end

        cmp_p     = {cmp_s[CAPACITY-2:0], 1'b0};
        prev_v    = '0;
        prev_d[0] = '0;
        for (int i = 1; i < CAPACITY; i++) begin
            prev_v[i] = base_v[i-1];
            prev_d[i] = base_d[i-1];
        end

        // insertion point is the first slot kvi beats; everything from there shifts down
        for (int i = 0; i < CAPACITY; i++) begin
            if (do_enq && cmp_s[i] && !cmp_p[i]) begin
                nxt_v[i] = 1'b1;
                nxt_d[i] = kvi;
            end else if (do_enq && cmp_s[i]) begin
                nxt_v[i] = prev_v[i];
                nxt_d[i] = prev_d[i];
            end else begin
                nxt_v[i] = base_v[i];
                nxt_d[i] = base_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v <= '0;
            for (int i = 0; i < CAPACITY; i++) slot_d[i] <= '0;
            cnt    <= '0;
            err_r  <= 1'b0;
        end else begin
            slot_v <= nxt_v;
            for (int i = 0; i < CAPACITY; i++) slot_d[i] <= nxt_d[i];
            cnt    <= cnt + CW'(do_enq) - CW'(do_deq);
            err_r  <= err_nxt;
        end
    end

    assign kvo   = slot_v[0] ? slot_d[0] : '0;
    assign kvo_v = slot_v[0];
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(CAPACITY));
    assign count = cnt;
    assign err   = err_r;

endmodule

// File: tb/tb_sr_pq_param.sv
// tb/tb_sr_pq_param.sv - MIN and MAX queue instances checked against sorted-list models
module tb_sr_pq_param;
    localparam int CAP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enq = 1'b0, deq = 1'b0;
    logic [63:0] kvi = '0;

    logic [63:0] kvo_mn, kvo_mx;
    logic        v_mn, v_mx, e_mn, e_mx, f_mn, f_mx, err_mn, err_mx;
    logic [3:0]  cnt_mn, cnt_mx;

    int passed = 0, failed = 0, total = 0;
    logic [63:0] qmin[$];
    logic [63:0] qmax[$];
    logic        exp_err = 1'b0;
    logic [63:0] ord_min [4];
    logic [63:0] ord_max [4];

    always #5 clk = ~clk;

    sr_pq_param #(.KEY_WIDTH(32), .VAL_WIDTH(32), .CAPACITY(CAP), .PQ_TYPE(pq_pkg::MIN_PQ)) dut_min (
        .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi),
        .kvo(kvo_mn), .kvo_v(v_mn), .empty(e_mn), .full(f_mn), .count(cnt_mn), .err(err_mn));

    sr_pq_param #(.KEY_WIDTH(32), .VAL_WIDTH(32), .CAPACITY(CAP), .PQ_TYPE(pq_pkg::MAX_PQ)) dut_max (
        .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi),
        .kvo(kvo_mx), .kvo_v(v_mx), .empty(e_mx), .full(f_mx), .count(cnt_mx), .err(err_mx));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stable insert: new entry lands in front of the first entry it strictly outranks
    function automatic int find_pos(input bit mx, input logic [63:0] kv, input logic [63:0] q[$]);
        for (int i = 0; i < q.size(); i++) begin
            if (mx ? (kv[63:32] > q[i][63:32]) : (kv[63:32] < q[i][63:32])) return i;
        end
        return q.size();
    endfunction

    task automatic model_step(input bit e, input bit d, input logic [63:0] kv);
        int sz = qmin.size();
        exp_err = (e && !d && sz == CAP) || (d && sz == 0);
        if (d && sz > 0) begin
            void'(qmin.pop_front());
            void'(qmax.pop_front());
        end
        if (e && (sz < CAP || d)) begin
            qmin.insert(find_pos(1'b0, kv, qmin), kv);
            qmax.insert(find_pos(1'b1, kv, qmax), kv);
        end
    endtask

    task automatic check_all();
        logic [63:0] hmin = (qmin.size() > 0) ? qmin[0] : 64'd0;
        logic [63:0] hmax = (qmax.size() > 0) ? qmax[0] : 64'd0;
        chk("min_kvo",   kvo_mn, hmin);
        chk("min_kvo_v", 64'(v_mn), 64'(qmin.size() > 0));
        chk("min_count", 64'(cnt_mn), 64'(qmin.size()));
        chk("min_empty", 64'(e_mn), 64'(qmin.size() == 0));
        chk("min_full",  64'(f_mn), 64'(qmin.size() == CAP));
        chk("min_err",   64'(err_mn), 64'(exp_err));
        chk("max_kvo",   kvo_mx, hmax);
        chk("max_kvo_v", 64'(v_mx), 64'(qmax.size() > 0));
        chk("max_count", 64'(cnt_mx), 64'(qmax.size()));
        chk("max_empty", 64'(e_mx), 64'(qmax.size() == 0));
        chk("max_full",  64'(f_mx), 64'(qmax.size() == CAP));
        chk("max_err",   64'(err_mx), 64'(exp_err));
    endtask

    task automatic do_op(input bit e, input bit d, input logic [63:0] kv);
        enq = e;
        deq = d;
        kvi = kv;
        @(posedge clk);
        #1;
        model_step(e, d, kv);
        check_all();
    endtask

    initial begin
        ord_min = '{{32'd3, 32'd2}, {32'd3, 32'd7}, {32'd5, 32'd1}, {32'd9, 32'd3}};
        ord_max = '{{32'd9, 32'd3}, {32'd5, 32'd1}, {32'd3, 32'd2}, {32'd3, 32'd7}};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // ordering and stable ties
        do_op(1, 0, {32'd5, 32'd1});
        do_op(1, 0, {32'd3, 32'd2});
        do_op(1, 0, {32'd9, 32'd3});
        do_op(1, 0, {32'd3, 32'd7});
        chk("min_head4", kvo_mn, {32'd3, 32'd2});
        chk("max_head4", kvo_mx, {32'd9, 32'd3});
        chk("min_cnt4",  64'(cnt_mn), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("min_order", kvo_mn, ord_min[k]);
            chk("max_order", kvo_mx, ord_max[k]);
            do_op(0, 1, '0);
        end

        // extreme keys are ordinary keys
        do_op(1, 0, {32'h0, 32'h11});
        do_op(1, 0, {32'hFFFFFFFF, 32'h22});
        chk("min_zero_key", kvo_mn, {32'h0, 32'h11});
        chk("max_ones_key", kvo_mx, {32'hFFFFFFFF, 32'h22});
        chk("ext_cnt", 64'(cnt_mx), 64'd2);
        do_op(0, 1, '0);
        do_op(0, 1, '0);

        // full: reject enq-only, accept replace
        for (int k = 0; k < CAP; k++) do_op(1, 0, {32'($urandom_range(10, 99)), 32'($urandom)});
        chk("full_flag", 64'(f_mn), 64'd1);
        do_op(1, 0, {32'd2, 32'hDEAD});
        chk("full_err", 64'(err_mn), 64'd1);
        do_op(0, 0, '0);
        do_op(1, 1, {32'd1, 32'hAB});
        chk("replace_head", kvo_mn, {32'd1, 32'hAB});
        chk("replace_cnt",  64'(cnt_mn), 64'd8);
        for (int k = 0; k < CAP; k++) do_op(0, 1, '0);

        // empty: deq rejected, enq+deq still inserts
        do_op(0, 1, '0);
        chk("empty_deq_err", 64'(err_mn), 64'd1);
        do_op(1, 1, {32'd4, 32'h44});
        chk("empty_rep_err", 64'(err_mx), 64'd1);
        chk("empty_rep_cnt", 64'(cnt_mn), 64'd1);
        chk("empty_rep_kvo", kvo_mn, {32'd4, 32'h44});
        do_op(0, 1, '0);

        // random traffic with many tied and extreme keys
        for (int n = 0; n < 1000; n++) begin
            int r = $urandom_range(0, 9);
            logic [31:0] key = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFFFFFF : 32'($urandom_range(0, 7));
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {key, 32'($urandom)});
        end

        // asynchronous reset mid-burst
        while (qmin.size() > 0) do_op(0, 1, '0);
        for (int k = 0; k < 6; k++) do_op(1, 0, {32'($urandom_range(0, 20)), 32'($urandom)});
        chk("pre_rst_cnt", 64'(cnt_mn), 64'd6);
        enq = 1'b1;
        kvi = {32'd7, 32'd7};
        #3;
        rst_n = 1'b0;
        #1;
        qmin.delete();
        qmax.delete();
        exp_err = 1'b0;
        check_all();
        enq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 0, '0);
        do_op(1, 0, {32'd6, 32'd66});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
